// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// One quotient bit per cycle, a divide-by-zero shortcut, and annul support.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, raw_a;
  logic             quot_neg, rem_neg;

  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             load, step, fin_div, fin_zero;

  // Operand magnitudes; the most-negative value maps to its own bit pattern.
  always_comb begin
    mag_a = (is_signed && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    mag_b = (is_signed && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;
  end

  // One restoring iteration: shift, trial subtract, keep on non-negative.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    fits     = (shifted >= {1'b0, dvs});
    rem_step = fits ? WIDTH'(trial) : WIDTH'(shifted);
    quo_step = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    fin_div   = 1'b0;
    fin_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          stall     = 1'b1;
          load      = 1'b1;
          state_nxt = (opb == '0) ? ZERO : BUSY;
        end
      end
      BUSY: begin
        if (annul) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          if (cnt == LAST) begin
            fin_div   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ZERO: begin
        if (annul) begin
          state_nxt = IDLE;
        end else begin
          stall     = 1'b1;
          fin_zero  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers; results land on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      raw_a    <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= fin_div | fin_zero;
      busy  <= (state_nxt != IDLE);
      if (load) begin
        cnt      <= '0;
        rem      <= '0;
        quo      <= mag_a;
        dvs      <= mag_b;
        raw_a    <= opa;
        quot_neg <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        rem_neg  <= is_signed & opa[WIDTH-1];
      end
      if (step) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt + CW'(1);
      end
      if (fin_div) begin
        lo_out <= quot_neg ? (~quo_step + WIDTH'(1)) : quo_step;
        hi_out <= rem_neg  ? (~rem_step + WIDTH'(1)) : rem_step;
      end
      if (fin_zero) begin
        lo_out <= '1;
        hi_out <= raw_a;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed table, corner sequences,
// and random operands checked against a 64-bit arithmetic reference.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, annul;
  logic [31:0] opa, opb;
  logic        stall, valid, busy;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .annul(annul),
    .opa(opa), .opb(opb), .stall(stall), .valid(valid),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
    int          poke;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit truncating division, results reduced mod 2^32.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else begin
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endfunction

  // Launch a divide at the current cycle (cycle 0) and check the whole profile.
  // poke > 0 re-pulses start with junk operands in that cycle.
  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] elo, input logic [31:0] ehi,
                        input int lat, input int poke);
    int prof_err = 0;
    int vcyc = -1;
    int vcount = 0;
    logic [31:0] clo = '0;
    logic [31:0] chi = '0;
    opa = a; opb = b; is_signed = s; start = 1'b1;
    for (int c = 0; c <= lat + 3; c++) begin
      @(negedge clk);
      if (stall !== (c < lat)) prof_err++;
      if (busy !== (c >= 1 && c <= lat)) prof_err++;
      if (valid === 1'b1) begin
        vcount++;
        if (vcyc < 0) begin
          vcyc = c;
          clo  = lo_out;
          chi  = hi_out;
        end
      end
      tick();
      start     = (c + 1 == poke);
      opa       = $urandom;
      opb       = $urandom;
      is_signed = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check({nm, "_valid_cycle"}, 64'(vcyc), 64'(lat));
    check({nm, "_valid_count"}, 64'(vcount), 64'd1);
    check({nm, "_stall_busy_profile"}, 64'(prof_err), 64'd0);
    check({nm, "_lo"}, 64'(clo), 64'(elo));
    check({nm, "_hi"}, 64'(chi), 64'(ehi));
    check({nm, "_hold"}, {hi_out, lo_out}, {ehi, elo});
  endtask

  initial begin
    logic [31:0] ra, rb, elo, ehi;
    logic        rs;
    int          vseen;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {stall, valid, busy, hi_out, lo_out}, 67'd0);
    tick();

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33, 5});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, -1});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,          33, -1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,          33, -1});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,          32'h8000_0000, 33, -1});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,          33, 33});
    vecs.push_back('{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,         32'hFFFF_FFFE, 33, -1});
    vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF, 32'd5,          2,  -1});
    vecs.push_back('{32'hFFFF_FFF7, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF7, 2,  2});
    vecs.push_back('{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          33, -1});
    foreach (vecs[i])
      do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].lo, vecs[i].hi, vecs[i].lat, vecs[i].poke);

    // Annul in cycle 10 of a divide, then a fresh start in cycle 11.
    do_div("pre_annul", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, -1);
    opa = 32'd1000; opb = 32'd3; is_signed = 1'b0; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      start = 1'b0;
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul_busy_stall", {stall, valid}, 2'b00);
    tick();
    annul = 1'b0;
    check("annul_idle", {busy, valid, hi_out, lo_out}, {1'b0, 1'b0, 32'd2, 32'd14});
    do_div("post_annul", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, -1);

    // Annul together with start: nothing launches.
    opa = 32'd8; opb = 32'd2; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    check("annul_with_start_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("annul_with_start_idle", {busy, valid}, 2'b00);
    tick();

    // Annul during the divide-by-zero cycle.
    opa = 32'd5; opb = 32'd0; start = 1'b1;
    tick();
    start = 1'b0; annul = 1'b1;
    @(negedge clk);
    check("annul_zero_stall", 64'(stall), 64'd0);
    tick();
    annul = 1'b0;
    @(negedge clk);
    check("annul_zero_after", {busy, valid, hi_out, lo_out}, {1'b0, 1'b0, 32'd0, 32'd10});
    tick();

    // Annul in DONE does not suppress valid.
    opa = 32'd200; opb = 32'd10; is_signed = 1'b0; start = 1'b1;
    for (int c = 0; c < 33; c++) begin
      tick();
      start = 1'b0;
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul_done_valid", {valid, lo_out, hi_out}, {1'b1, 32'd20, 32'd0});
    tick();
    annul = 1'b0;
    @(negedge clk);
    check("annul_done_after", {busy, valid}, 2'b00);
    tick();

    // Reset in cycle 20 of a divide.
    opa = 32'd77; opb = 32'd5; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      start = 1'b0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs", {stall, valid, busy, hi_out, lo_out}, 67'd0);
    vseen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid === 1'b1 || busy === 1'b1) vseen++;
    end
    check("mid_reset_quiet", 64'(vseen), 64'd0);
    tick();

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 255));
        default: ra = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, elo, ehi);
      do_div($sformatf("rnd%0d", i), ra, rb, rs, elo, ehi, (rb == 32'd0) ? 2 : 33, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle radix-2 restoring divider with its sequencing FSM, serving the execute stage's DIV/DIVU instructions.
- Accepts a start pulse from the EX stage and holds the pipeline stall request while iterating.
- Delivers the quotient for LO and the remainder for HI, with a one-cycle valid, for the HI/LO register write.
- Supports a pipeline annul (flush) that abandons an in-flight divide.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a divide; sampled only in IDLE
- is_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with start
- annul  input  1  flush; cancels the current operation
- opa  input  WIDTH  dividend (rs); sampled with start
- opb  input  WIDTH  divisor (rt); sampled with start
- stall  output  1  pipeline hold request
- valid  output  1  one-cycle pulse; hi_out/lo_out hold the result
- hi_out  output  WIDTH  remainder
- lo_out  output  WIDTH  quotient
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: state = IDLE, counter = 0, stall = 0, valid = 0, busy = 0, hi_out = 0, lo_out = 0. Reset wins over every other input, including mid-operation; no valid pulse is produced.
- States: IDLE, BUSY, ZERO, DONE.
- IDLE with start=1 and annul=0 (cycle N):
  - latch |opa| and |opb| (magnitudes when is_signed=1, raw values otherwise);
  - latch quot_neg = is_signed & (opa[MSB] ^ opb[MSB]) and rem_neg = is_signed & opa[MSB];
  - next state is ZERO if opb == 0, else BUSY with counter = 0.
- stall is combinational: stall = (IDLE & start & ~annul) | BUSY | ZERO. It is high in cycle N so the EX instruction holds.
- BUSY, one iteration per cycle:
  - {rem,quo} shift left 1;
  - trial = rem - divisor (WIDTH+1 bits);
  - if trial is non-negative, rem = trial and quo[0] = 1;
  - counter increments; after WIDTH iterations (cycles N+1..N+WIDTH), go to DONE.
- DONE (cycle N+WIDTH+1):
  - valid = 1, stall = 0;
  - lo_out = quot_neg ? -quo : quo, hi_out = rem_neg ? -rem : rem;
  - next state IDLE.
  - Latency for WIDTH=32 is start in cycle N, valid in cycle N+33.
- ZERO (divide by zero), cycle N+1, stall high. Next cycle is DONE with lo_out = all ones and hi_out = opa (raw). Total latency is 2 cycles.
- hi_out/lo_out keep their last result after valid drops. They change only in DONE or on reset.
- Overflow case: signed -2^(WIDTH-1) / -1 gives lo_out = 0x80000000, hi_out = 0. This falls out of unsigned magnitude arithmetic with wrap; no special-casing.
- annul in BUSY, ZERO, or same-cycle with start: next state IDLE, no valid. stall drops combinationally in the same cycle annul is seen.
  - annul in DONE: valid still asserts that cycle. The consumer (HI/LO write enable) gates with its own flush.
- start outside IDLE is ignored; no queuing.
- start in DONE is ignored. A new divide needs start in the following IDLE cycle, so back-to-back throughput is one divide per WIDTH+2 cycles.
- Arithmetic: magnitude of the most-negative value is its unsigned bit pattern. Negation is two's complement modulo 2^WIDTH.

Test Plan:
- Unsigned: DIVU 100/7, start in cycle 0 -> stall cycles 0..32, valid only in cycle 33, lo_out = 14, hi_out = 2.
- Signed: DIV -7/2 -> lo_out = 0xFFFFFFFD (-3), hi_out = 0xFFFFFFFF (-1). DIV 7/-2 -> lo_out = -3, hi_out = 1.
- Edge cases: DIV 0x80000000 / 0xFFFFFFFF -> lo_out = 0x80000000, hi_out = 0. DIVU 0xFFFFFFFF/1 -> lo_out = 0xFFFFFFFF, hi_out = 0.
- Divide by zero: DIVU 5/0 -> valid in cycle 2, lo_out = 0xFFFFFFFF, hi_out = 5, stall high in cycles 0..1 only.
- Annul: annul in cycle 10 of an active divide -> stall low in cycle 10, IDLE in cycle 11, no valid, hi_out/lo_out unchanged. A fresh start in cycle 11 completes normally in cycle 44.
- Reset and ignored start:
  - rst asserted in cycle 20 of a divide -> all outputs 0 from cycle 21, no valid.
  - start pulsed in cycle 5 while BUSY -> ignored, first result unaffected.
